// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART TX line between NUM_REQ byte requesters.
// Each grant sends one 8N1-style frame timed by the 16x oversample tick.
module uart_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tick,
    output logic                           baud_en,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   data,
    output logic [NUM_REQ-1:0]             ack,
    output logic [ID_WIDTH-1:0]            grant_id,
    output logic                           busy,
    output logic                           tx,
    output logic                           frame_done
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q, state_d;
    logic [ID_WIDTH-1:0]    ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]    grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic                   baud_en_q, baud_en_d;
    logic                   tx_q, tx_d;
    logic                   frame_done_q, frame_done_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;

    logic                   found;
    logic [ID_WIDTH-1:0]    sel;
    logic                   bit_end;

    // First requester at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[(int'(ptr_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                sel   = ID_WIDTH'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

    assign bit_end = busy_q && tick && (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_id_d   = grant_id_q;
        ack_d        = '0;
        busy_d       = busy_q;
        baud_en_d    = baud_en_q;
        tx_d         = tx_q;
        frame_done_d = 1'b0;
        shift_d      = shift_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;

        if (busy_q && tick)
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (found) begin
                    shift_d    = data[int'(sel)*DATA_BITS +: DATA_BITS];
                    ack_d      = NUM_REQ'(1) << sel;
                    grant_id_d = sel;
                    ptr_d      = ID_WIDTH'((int'(sel) + 1) % NUM_REQ);
                    busy_d     = 1'b1;
                    baud_en_d  = 1'b1;
                    tx_d       = 1'b0;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        tx_d      = 1'b1;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d    = '0;
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        baud_en_d    = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grant_id_q   <= '0;
            ack_q        <= '0;
            busy_q       <= 1'b0;
            baud_en_q    <= 1'b0;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
            shift_q      <= '0;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_id_q   <= grant_id_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            baud_en_q    <= baud_en_d;
            tx_q         <= tx_d;
            frame_done_q <= frame_done_d;
            shift_q      <= shift_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
        end
    end

    assign baud_en    = baud_en_q;
    assign ack        = ack_q;
    assign grant_id   = grant_id_q;
    assign busy       = busy_q;
    assign tx         = tx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a tick-count frame model checked every cycle,
// plus literal expectations for grant order, bit pattern and reset behaviour.
module tb_uart_tx_scheduler;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int OS = 16;
    localparam int FL = OS * (1 + DB + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            tick = 1'b0;
    logic            baud_en;
    logic [N-1:0]    req = '0;
    logic [N*DB-1:0] data = {8'h3C, 8'hA5, 8'h5A, 8'h81};
    logic [N-1:0]    ack;
    logic [1:0]      grant_id;
    logic            busy;
    logic            tx;
    logic            frame_done;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(N), .DATA_BITS(DB), .STOP_BITS(1), .OVERSAMPLE(OS)) dut (
        .clk(clk), .reset(reset), .tick(tick), .baud_en(baud_en), .req(req), .data(data),
        .ack(ack), .grant_id(grant_id), .busy(busy), .tx(tx), .frame_done(frame_done)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Frame model: a frame is just FL ticks; bit k of the frame covers ticks [k*OS, (k+1)*OS).
    logic         m_busy = 1'b0, m_fd = 1'b0, m_tx = 1'b1;
    logic [N-1:0] m_ack = '0;
    int           m_grant = 0, m_ptr = 0, m_ticks = 0;
    logic [DB-1:0] m_byte = '0;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic frame_bit(input logic [DB-1:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DB) return b[idx-1];
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_busy = 0; m_fd = 0; m_tx = 1; m_ack = '0; m_grant = 0; m_ptr = 0; m_ticks = 0;
        end else begin
            m_ack = '0;
            m_fd  = 0;
            if (!m_busy) begin
                if (req != '0) begin
                    m_grant = rr_pick(req, m_ptr);
                    m_ack   = N'(1) << m_grant;
                    m_ptr   = (m_grant + 1) % N;
                    m_byte  = data[m_grant*DB +: DB];
                    m_busy  = 1; m_ticks = 0; m_tx = 0;
                end
            end else if (tick) begin
                m_ticks++;
                if (m_ticks == FL) begin
                    m_busy = 0; m_fd = 1; m_tx = 1;
                end else begin
                    m_tx = frame_bit(m_byte, m_ticks / OS);
                end
            end
        end
    end

    bit   chk_en = 0;
    bit   rec_tx = 0;
    int   glog[$];
    logic txs[$];
    int   fd_cnt = 0;
    int   ack3_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("tx", tx, m_tx);
            check("busy", busy, m_busy);
            check("baud_en", baud_en, m_busy);
            check("ack", ack, m_ack);
            check("grant_id", grant_id, m_grant);
            check("frame_done", frame_done, m_fd);
        end
        if (ack != '0) glog.push_back(int'(grant_id));
        if (ack[3]) ack3_cnt++;
        if (frame_done) fd_cnt++;
        if (rec_tx && busy && tick) txs.push_back(tx);
    end

    int cyc = 0;
    int tick_div = 0;
    bit auto_drop = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (auto_drop) req = req & ~ack;
        tick = (tick_div != 0) && (cyc % tick_div == 0);
    endtask

    task automatic wait_ack(input string nm, input int maxc);
        int n = 0;
        do begin step(); n++; end while (ack == '0 && n < maxc);
        nchk++;
        if (ack == '0) begin
            nerr++;
            $display("FAIL %s: no ack within %0d cycles", nm, maxc);
        end
    endtask

    task automatic wait_fd(input string nm, input int maxc);
        int n = 0;
        do begin step(); n++; end while (!frame_done && n < maxc);
        nchk++;
        if (!frame_done) begin
            nerr++;
            $display("FAIL %s: no frame_done within %0d cycles", nm, maxc);
        end
    endtask

    logic [9:0] exp_bits;

    initial begin
        // Reset state
        step(); step();
        chk_en = 1;
        check("rst tx", tx, 1); check("rst busy", busy, 0); check("rst baud_en", baud_en, 0);
        check("rst ack", ack, 0); check("rst grant_id", grant_id, 0); check("rst frame_done", frame_done, 0);
        reset = 0;

        // Free-running ticks with no request
        tick_div = 1;
        repeat (100) step();
        check("idle tx", tx, 1); check("idle busy", busy, 0); check("idle acks", glog.size(), 0);

        // Single frame from requester 2, byte A5
        fd_cnt = 0; rec_tx = 1; auto_drop = 1; tick_div = 2;
        req = 4'b0100;
        wait_ack("single", 10);
        check("single ack", ack, 4'b0100);
        check("single grant", grant_id, 2);
        step();
        check("single ack pulse", ack, 0);
        wait_fd("single", 2 * FL + 10);
        rec_tx = 0;
        check("single ticks", txs.size(), FL);
        exp_bits = 10'b1_10100101_0;
        for (int k = 0; k < 10; k++)
            if (txs.size() > 16*k + 8) check($sformatf("single bit%0d", k), txs[16*k + 8], exp_bits[k]);
        step();
        check("single fd count", fd_cnt, 1);

        // Pointer sits at 3: requester 3 must beat requester 0
        glog.delete();
        req = 4'b1001;
        wait_ack("fair1", 10);
        wait_fd("fair1", 2 * FL + 10);
        wait_ack("fair2", 10);
        wait_fd("fair2", 2 * FL + 10);
        check("fair count", glog.size(), 2);
        if (glog.size() == 2) begin
            check("fair first", glog[0], 3);
            check("fair second", glog[1], 0);
        end

        // Round-robin from pointer 0 with all requests held
        reset = 1; step(); reset = 0;
        glog.delete(); auto_drop = 0; tick_div = 1;
        req = 4'hF;
        repeat (6) wait_fd("rr", FL + 10);
        req = '0;
        step();
        check("rr count", glog.size(), 6);
        if (glog.size() == 6) begin
            check("rr g0", glog[0], 0); check("rr g1", glog[1], 1); check("rr g2", glog[2], 2);
            check("rr g3", glog[3], 3); check("rr g4", glog[4], 0); check("rr g5", glog[5], 1);
        end

        // Reset during data bit 3 of a frame from requester 1
        fd_cnt = 0;
        req = 4'b0010;
        wait_ack("mid", 10);
        repeat (70) step();
        reset = 1;
        step();
        check("mid tx", tx, 1); check("mid busy", busy, 0); check("mid baud_en", baud_en, 0);
        check("mid frame_done", frame_done, 0); check("mid ack", ack, 0);
        reset = 0;
        step();
        check("mid regrant ack", ack, 4'b0010);
        check("mid regrant id", grant_id, 1);
        check("mid no fd", fd_cnt, 0);
        req = '0;
        wait_fd("mid", FL + 10);

        // Request 3 pulsed and withdrawn during a frame from requester 0
        glog.delete(); ack3_cnt = 0; auto_drop = 1; tick_div = 2;
        req = 4'b0001;
        wait_ack("wd", 10);
        repeat (50) step();
        req[3] = 1'b1;
        repeat (20) step();
        req[3] = 1'b0;
        wait_fd("wd", 2 * FL + 10);
        step(); step();
        check("wd ack3", ack3_cnt, 0);
        check("wd grants", glog.size(), 1);
        if (glog.size() == 1) check("wd grant0", glog[0], 0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
